// File: rtl/signed_add_arb_pkg.sv
// Shared definitions for the signed_add_arbiter slice: default sizes,
// id width helper, saturation constants and the output-stage state type.
package signed_add_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;

  // Width of a requester index; never less than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp values for the default operand width.
  localparam logic [DEF_W-1:0] MAX_POS = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic [DEF_W-1:0] MAX_NEG = {1'b1, {(DEF_W-1){1'b0}}};

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/signed_add_arb_if.sv
// Bundle of requester and result signals around the shared adder.
// Handshake: a transfer happens on a clock edge where valid and ready are
// both 1; a requester holds its operands stable while valid=1 and ready=0,
// and the result side holds its outputs while res_valid=1 and res_ready=0.
// 'state' mirrors the output-stage FSM for observation.
interface signed_add_arb_if
  import signed_add_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  logic [W-1:0]       res_sum;
  logic               res_overflow;
  logic [ID_W-1:0]    res_id;
  logic [CNT_W-1:0]   ovf_count;
  out_state_t         state;

  // Client side: presents operands and consumes results.
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_overflow, res_id, ovf_count, state
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_overflow, res_id, ovf_count, state
  );
endinterface

// File: rtl/signed_add_arbiter_ovf_core.sv
// signed_add_ovf_core: combinational W-bit two's-complement adder with
// signed-overflow flag. With SIGNED_ADD_ARB_SATURATE_EN defined the sum is
// clamped to the most positive / most negative value on overflow.
module signed_add_ovf_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         overflow
);
  logic [W-1:0] raw;

  // Wrapped sum; overflow when operand signs agree and the result sign differs.
  always_comb begin
    raw      = a + b;
    overflow = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
  end

`ifdef SIGNED_ADD_ARB_SATURATE_EN
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  // Clamp toward the sign of the operands (both equal when overflowing).
  always_comb begin
    sum = raw;
    if (overflow) sum = a[W-1] ? SAT_NEG : SAT_POS;
  end
`else
  // Plain modular result.
  always_comb begin
    sum = raw;
  end
`endif
endmodule

// File: rtl/signed_add_arbiter.sv
// signed_add_arbiter: round-robin arbiter sharing one signed adder among
// N_REQ requesters, with a single-entry result register tagged by requester
// id and a saturating overflow-event counter.
// Optional macro SIGNED_ADD_ARB_SATURATE_EN clamps the sum on overflow.
module signed_add_arbiter
  import signed_add_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst,
  signed_add_arb_if.slave bus
);
  localparam int ID_W = id_width(N_REQ);

  out_state_t        state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic              can_accept;
  logic              accept;
  logic [N_REQ-1:0]  ready_c;
  logic [W-1:0]      a_sel, b_sel;
  logic [W-1:0]      core_sum;
  logic              core_ovf;
  logic [W-1:0]      sum_q;
  logic              ovf_q;
  logic [ID_W-1:0]   id_q;
  logic [CNT_W-1:0]  cnt_q;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  // One-hot ready, only when the output stage can take data and not in reset.
  always_comb begin
    can_accept = (state_q == ST_EMPTY) || bus.res_ready;
    accept     = grant_found && can_accept && !rst;
    ready_c    = '0;
    if (accept) ready_c[grant_idx] = 1'b1;
    a_sel = bus.req_a[int'(grant_idx)*W +: W];
    b_sel = bus.req_b[int'(grant_idx)*W +: W];
  end

  signed_add_ovf_core #(.W(W)) u_core (
    .a        (a_sel),
    .b        (b_sel),
    .sum      (core_sum),
    .overflow (core_ovf)
  );

  // Output-stage occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Fill on accept (also covers drain+accept), empty on drain, else hold.
  always_comb begin
    state_d = state_q;
    if (accept)             state_d = ST_FULL;
    else if (bus.res_ready) state_d = ST_EMPTY;
  end

  // Result payload and round-robin pointer update only on an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
      id_q  <= '0;
      ptr_q <= '0;
    end else if (accept) begin
      sum_q <= core_sum;
      ovf_q <= core_ovf;
      id_q  <= grant_idx;
      ptr_q <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Overflow events counted at accept time, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  cnt_q <= '0;
    else if (accept && core_ovf && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.req_ready    = ready_c;
  assign bus.res_valid    = (state_q == ST_FULL);
  assign bus.res_sum      = sum_q;
  assign bus.res_overflow = ovf_q;
  assign bus.res_id       = id_q;
  assign bus.ovf_count    = cnt_q;
  assign bus.state        = state_q;
endmodule
